// File: rtl/nios2_oci_dct_packer_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// nios2_oci_dct_pkg : shared widths, FSM states, fit check  (rev 1.0)
// ------------------------------------------------------------------
package nios2_oci_dct_pkg;

  localparam int BUF_W     = 30;
  localparam int UNIT_W    = 2;
  localparam int CNT_W     = 4;
  localparam int STAT_W    = 16;
  localparam int LEN_W     = 2;
  localparam int FRAG_W    = 3 * UNIT_W;
  localparam int MAX_UNITS = BUF_W / UNIT_W;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_UNITS);

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_EMIT  = 2'd1,
    ST_ENDED = 2'd2
  } state_t;

  // One extra bit so count + len cannot wrap before the compare.
  function automatic logic fits(input logic [CNT_W-1:0] count, input logic [LEN_W-1:0] len);
    return ({1'b0, count} + {{(CNT_W-LEN_W+1){1'b0}}, len}) <= (CNT_W+1)'(MAX_UNITS);
  endfunction

endpackage
`default_nettype wire

// File: rtl/nios2_oci_dct_packer_if.sv
`default_nettype none
// ------------------------------------------------------------------
// nios2_oci_dct_packer_if : fragment-in / word-out handshakes (rev 1.0)
// ------------------------------------------------------------------
interface nios2_oci_dct_packer_if
  import nios2_oci_dct_pkg::*;
  ;

  logic              frag_valid;
  logic              frag_ready;
  logic [FRAG_W-1:0] frag_data;
  logic [LEN_W-1:0]  frag_len;
  logic              word_valid;
  logic              word_ready;
  logic [BUF_W-1:0]  word_data;
  logic [CNT_W-1:0]  word_units;

  modport master (
    output frag_valid, frag_data, frag_len, word_ready,
    input  frag_ready, word_valid, word_data, word_units
  );

  modport slave (
    input  frag_valid, frag_data, frag_len, word_ready,
    output frag_ready, word_valid, word_data, word_units
  );

endinterface
`default_nettype wire

// File: rtl/nios2_oci_dct_packer_insert.sv
`default_nettype none
// ------------------------------------------------------------------
// nios2_oci_dct_insert : places a masked fragment above count units (rev 1.0)
// ------------------------------------------------------------------
module nios2_oci_dct_insert
  import nios2_oci_dct_pkg::*;
(
  input  logic [BUF_W-1:0]  buffer,
  input  logic [CNT_W-1:0]  count,
  input  logic [FRAG_W-1:0] frag_data,
  input  logic [LEN_W-1:0]  frag_len,
  output logic [BUF_W-1:0]  next_buffer,
  output logic [CNT_W-1:0]  next_count
);

  logic [FRAG_W-1:0] frag_mask;
  logic [BUF_W-1:0]  frag_ext;
  logic [CNT_W:0]    shamt;

  // Unused upper units are masked so bits above count stay zero.
  always_comb begin
    frag_mask = '0;
    case (frag_len)
      2'd1:    frag_mask = 6'h03;
      2'd2:    frag_mask = 6'h0F;
      2'd3:    frag_mask = 6'h3F;
      default: frag_mask = '0;
    endcase
  end

  assign frag_ext    = BUF_W'(frag_data & frag_mask);
  assign shamt       = {count, 1'b0};
  assign next_buffer = buffer | (frag_ext << shamt);
  assign next_count  = count + {{(CNT_W-LEN_W){1'b0}}, frag_len};

endmodule
`default_nettype wire

// File: rtl/nios2_oci_dct_packer.sv
`default_nettype none
// ------------------------------------------------------------------
// nios2_oci_dct_packer : DCT trace packing FSM, emit handshake, drain (rev 1.0)
// ------------------------------------------------------------------
module nios2_oci_dct_packer
  import nios2_oci_dct_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset_n,
  nios2_oci_dct_packer_if.slave   bus,
  input  logic                    flush,
  input  logic                    test_ending,
  output logic [BUF_W-1:0]        dct_buffer,
  output logic [CNT_W-1:0]        dct_count,
  output logic                    test_has_ended,
  output logic [STAT_W-1:0]       word_cnt
);

  state_t           state;
  logic             ending;
  logic             ending_now;
  logic             frag_fits;
  logic             in_accum;
  logic             accept;
  logic             count_nz;
  logic [BUF_W-1:0] next_buffer;
  logic [CNT_W-1:0] next_count;

  nios2_oci_dct_insert u_insert (
    .buffer      (dct_buffer),
    .count       (dct_count),
    .frag_data   (bus.frag_data),
    .frag_len    (bus.frag_len),
    .next_buffer (next_buffer),
    .next_count  (next_count)
  );

  assign ending_now = ending | test_ending;
  assign frag_fits  = fits(dct_count, bus.frag_len);
  assign in_accum   = (state == ST_ACCUM);
  assign count_nz   = (dct_count != '0);

  // Gated by reset_n so every output reads 0 while reset is held.
  assign bus.frag_ready = reset_n & in_accum & ~ending_now & ~flush & frag_fits;
  assign accept         = bus.frag_valid & bus.frag_ready;

  assign bus.word_valid = (state == ST_EMIT);
  assign bus.word_data  = bus.word_valid ? dct_buffer : '0;
  assign bus.word_units = bus.word_valid ? dct_count  : '0;
  assign test_has_ended = (state == ST_ENDED);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_ACCUM;
      ending     <= 1'b0;
      dct_buffer <= '0;
      dct_count  <= '0;
      word_cnt   <= '0;
    end else begin
      ending <= ending_now;
      case (state)
        ST_ACCUM: begin
          if (ending_now) begin
            state <= count_nz ? ST_EMIT : ST_ENDED;
          end else if (flush) begin
            if (count_nz) state <= ST_EMIT;
          end else if (accept) begin
            dct_buffer <= next_buffer;
            dct_count  <= next_count;
            if (next_count == MAX_CNT) state <= ST_EMIT;
          end else if (bus.frag_valid && count_nz) begin
            // Fragment does not fit: emit first, it is taken afterwards.
            state <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (bus.word_ready) begin
            dct_buffer <= '0;
            dct_count  <= '0;
            if (word_cnt != {STAT_W{1'b1}}) word_cnt <= word_cnt + STAT_W'(1);
            state <= ending_now ? ST_ENDED : ST_ACCUM;
          end
        end
        ST_ENDED: begin
          state <= ST_ENDED;
        end
        default: state <= ST_ACCUM;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nios2_oci_dct_packer.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_nios2_oci_dct_packer : directed + randomized checks against a unit-queue model (rev 1.0)
// ------------------------------------------------------------------
module tb_nios2_oci_dct_packer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        test_ending = 1'b0;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        test_has_ended;
  logic [15:0] word_cnt;

  logic auto_mode = 1'b0;
  logic rand_ready = 1'b0;
  logic dir_ready = 1'b0;

  int checks = 0;
  int failures = 0;
  int exp_words = 0;

  typedef struct {
    logic [29:0] data;
    int          n;
  } word_t;

  word_t       exp_q[$];
  int unsigned units[$];

  nios2_oci_dct_packer_if bus ();

  assign bus.word_ready = auto_mode ? rand_ready : dir_ready;

  nios2_oci_dct_packer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .bus            (bus),
    .flush          (flush),
    .test_ending    (test_ending),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .test_has_ended (test_has_ended),
    .word_cnt       (word_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [29:0] pack_units();
    logic [29:0] v;
    v = '0;
    for (int i = 0; i < units.size(); i++) v[2*i +: 2] = 2'(units[i]);
    return v;
  endfunction

  task automatic model_append(input logic [5:0] d, input int len);
    for (int i = 0; i < len; i++) units.push_back((32'(d) >> (2*i)) & 32'd3);
  endtask

  task automatic model_close();
    word_t w;
    w.data = pack_units();
    w.n    = units.size();
    exp_q.push_back(w);
    units.delete();
  endtask

  task automatic send(input logic [5:0] d, input int len);
    bus.frag_valid = 1'b1;
    bus.frag_data  = d;
    bus.frag_len   = 2'(len);
    #1;
    chk("send_frag_ready", bus.frag_ready, 1'b1);
    tick();
    bus.frag_valid = 1'b0;
    model_append(d, len);
    chk("send_dct_count", dct_count, units.size());
    chk("send_dct_buffer", dct_buffer, pack_units());
  endtask

  task automatic chk_word(input string tag);
    chk({tag, "_valid"}, bus.word_valid, 1'b1);
    chk({tag, "_data"}, bus.word_data, exp_q[0].data);
    chk({tag, "_units"}, bus.word_units, exp_q[0].n);
  endtask

  task automatic drain(input string tag);
    chk_word(tag);
    void'(exp_q.pop_front());
    dir_ready = 1'b1;
    tick();
    dir_ready = 1'b0;
    exp_words++;
    chk({tag, "_valid_drop"}, bus.word_valid, 1'b0);
    chk({tag, "_word_cnt"}, word_cnt, exp_words);
    chk({tag, "_count_clr"}, dct_count, 0);
  endtask

  // Randomized consumer: decides word_ready on the falling edge.
  initial begin
    word_t w;
    forever begin
      @(negedge clk);
      if (auto_mode) begin
        rand_ready = ($urandom_range(0, 3) != 0);
        if (bus.word_valid) begin
          chk("emit_frag_ready_low", bus.frag_ready, 1'b0);
          if (rand_ready) begin
            chk("word_expected", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
              w = exp_q.pop_front();
              chk("rand_word_data", bus.word_data, w.data);
              chk("rand_word_units", bus.word_units, w.n);
              exp_words++;
            end
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] d;
    int         len;
    int         w;

    bus.frag_valid = 1'b0;
    bus.frag_data  = '0;
    bus.frag_len   = 2'd1;

    // Reset values
    #1;
    chk("rst_frag_ready", bus.frag_ready, 1'b0);
    chk("rst_word_valid", bus.word_valid, 1'b0);
    chk("rst_dct_count", dct_count, 0);
    chk("rst_ended", test_has_ended, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    chk("post_rst_word_cnt", word_cnt, 0);
    chk("post_rst_dct_buffer", dct_buffer, 0);

    // 1: five 3-unit fragments fill the buffer
    for (int k = 0; k < 5; k++) send(6'h2D, 3);
    model_close();
    chk("t1_word_data_const", bus.word_data, 30'h2DB6DB6D);
    drain("t1");

    // 2: fragment that does not fit forces an emit and is then taken
    for (int k = 0; k < 4; k++) send(6'($urandom), 3);
    send(6'($urandom), 2);
    bus.frag_valid = 1'b1;
    bus.frag_data  = 6'h1B;
    bus.frag_len   = 2'd2;
    #1;
    chk("t2_no_fit_ready", bus.frag_ready, 1'b0);
    model_close();
    tick();
    chk("t2_emit_frag_ready", bus.frag_ready, 1'b0);
    drain("t2");
    chk("t2_retry_ready", bus.frag_ready, 1'b1);
    tick();
    bus.frag_valid = 1'b0;
    model_append(6'h1B, 2);
    chk("t2_dct_count", dct_count, 2);
    chk("t2_dct_buffer", dct_buffer, 30'h0B);

    // 3: flush beats a same-cycle fragment; flush when empty is a no-op
    send(6'($urandom), 3);
    flush = 1'b1;
    bus.frag_valid = 1'b1;
    bus.frag_len   = 2'd1;
    #1;
    chk("t3_flush_blocks_frag", bus.frag_ready, 1'b0);
    model_close();
    tick();
    flush = 1'b0;
    bus.frag_valid = 1'b0;
    drain("t3");
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t3_empty_flush_valid", bus.word_valid, 1'b0);
    tick();
    chk("t3_empty_flush_valid2", bus.word_valid, 1'b0);

    // 4: backpressure keeps the word stable
    send(6'($urandom), 3);
    send(6'($urandom), 3);
    flush = 1'b1;
    model_close();
    tick();
    flush = 1'b0;
    bus.frag_valid = 1'b1;
    bus.frag_len   = 2'd1;
    for (int k = 0; k < 10; k++) begin
      chk_word("t4_hold");
      chk("t4_hold_frag_ready", bus.frag_ready, 1'b0);
      tick();
    end
    bus.frag_valid = 1'b0;
    drain("t4");
    tick();
    chk("t4_single_valid", bus.word_valid, 1'b0);
    chk("t4_single_cnt", word_cnt, exp_words);

    // Randomized traffic against the unit-queue model
    rand_ready = 1'b0;
    auto_mode  = 1'b1;
    for (int n = 0; n < 80; n++) begin
      d   = 6'($urandom);
      len = $urandom_range(0, 3);
      if (len > 0 && units.size() + len > 15) model_close();
      bus.frag_valid = 1'b1;
      bus.frag_data  = d;
      bus.frag_len   = 2'(len);
      #1;
      w = 0;
      while (!bus.frag_ready && w < 200) begin
        @(posedge clk);
        #2;
        w++;
      end
      chk("rand_frag_ready", bus.frag_ready, 1'b1);
      tick();
      bus.frag_valid = 1'b0;
      model_append(d, len);
      chk("rand_dct_count", dct_count, units.size());
      chk("rand_dct_buffer", dct_buffer, pack_units());
      if (units.size() == 15) model_close();
      repeat ($urandom_range(0, 2)) tick();
    end
    if (units.size() > 0) begin
      model_close();
      flush = 1'b1;
      tick();
      flush = 1'b0;
    end
    w = 0;
    while (exp_q.size() > 0 && w < 500) begin
      tick();
      w++;
    end
    chk("rand_drain_empty", exp_q.size(), 0);
    tick();
    chk("rand_final_valid", bus.word_valid, 1'b0);
    chk("rand_word_cnt", word_cnt, exp_words);
    auto_mode = 1'b0;

    // 5: end-of-test drain
    send(6'($urandom), 3);
    send(6'($urandom), 3);
    send(6'($urandom), 1);
    bus.frag_valid = 1'b1;
    bus.frag_len   = 2'd1;
    #1;
    chk("t5_ready_before_end", bus.frag_ready, 1'b1);
    test_ending = 1'b1;
    #1;
    chk("t5_ready_drops", bus.frag_ready, 1'b0);
    model_close();
    tick();
    test_ending = 1'b0;
    bus.frag_valid = 1'b0;
    drain("t5");
    chk("t5_ended", test_has_ended, 1'b1);
    flush = 1'b1;
    bus.frag_valid = 1'b1;
    #1;
    chk("t5_ended_frag_ready", bus.frag_ready, 1'b0);
    tick();
    tick();
    flush = 1'b0;
    bus.frag_valid = 1'b0;
    chk("t5_ended_word_valid", bus.word_valid, 1'b0);
    chk("t5_ended_sticky", test_has_ended, 1'b1);
    chk("t5_ended_count", dct_count, 0);

    // 6: reset mid-EMIT drops the pending word
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    exp_words = 0;
    chk("t6_pre_ended", test_has_ended, 1'b0);
    chk("t6_pre_word_cnt", word_cnt, 0);
    for (int k = 0; k < 5; k++) send(6'($urandom), 3);
    model_close();
    chk("t6_in_emit", bus.word_valid, 1'b1);
    bus.frag_valid = 1'b1;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_word_valid", bus.word_valid, 1'b0);
    chk("t6_rst_word_data", bus.word_data, 0);
    chk("t6_rst_word_units", bus.word_units, 0);
    chk("t6_rst_dct_buffer", dct_buffer, 0);
    chk("t6_rst_dct_count", dct_count, 0);
    chk("t6_rst_frag_ready", bus.frag_ready, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    bus.frag_valid = 1'b0;
    exp_q.delete();
    units.delete();
    tick();
    chk("t6_post_count", dct_count, 0);
    chk("t6_post_word_cnt", word_cnt, 0);
    chk("t6_post_ended", test_has_ended, 1'b0);
    chk("t6_post_valid", bus.word_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nios2_oci_dct_packer.md
Name: nios2_oci_dct_packer

Overview:
Sequencer for the Nios II OCI debug compressed-trace (DCT) buffer. It accepts variable-length trace fragments and packs them LSB-first into a 30-bit buffer of 15 two-bit units. Full or flushed buffers are emitted to trace memory over a valid/ready handshake. It drives the dct_buffer/dct_count observation pair and sequences end-of-test drain through test_ending/test_has_ended.

Parameters:
BUF_W, 30, packed buffer width in bits
UNIT_W, 2, bits per trace unit
CNT_W, 4, width of unit counter; MAX_UNITS = BUF_W/UNIT_W = 15
STAT_W, 16, width of emitted-word counter

Ports:
clk  in  1  single clock, rising edge
reset_n  in  1  asynchronous active-low reset
frag_valid  in  1  fragment offered
frag_ready  out  1  fragment accepted this cycle when high with frag_valid
frag_data  in  6  fragment payload; unit 0 in bits [1:0]
frag_len  in  2  fragment length in units, 1..3; 0 = accepted no-op
flush  in  1  single-cycle request to emit a partial buffer
test_ending  in  1  end-of-test request, level or pulse
word_valid  out  1  packed word available
word_ready  in  1  trace memory accepts word
word_data  out  BUF_W  packed word
word_units  out  CNT_W  valid units in word_data, 1..15
dct_buffer  out  BUF_W  live packing buffer
dct_count  out  CNT_W  live unit count, 0..15
test_has_ended  out  1  drain complete, sticky until reset
word_cnt  out  STAT_W  words emitted, saturating

Behaviour:
- Reset: all outputs 0, state ACCUM, buffer/count/ending flag/word_cnt cleared. Reset in any state, including mid-EMIT, drops the pending word.
- States: ACCUM, EMIT, ENDED.
- ACCUM acceptance: frag_ready = (state==ACCUM) && !ending && !flush && (dct_count + frag_len <= 15). frag_ready depends combinationally on frag_len, which is intended.
- ACCUM accept: buffer[(count+i)*2 +: 2] <= frag_data[i*2 +: 2] for i < frag_len. count <= count + frag_len. Visible on dct_buffer/dct_count the next cycle, so latency is 1.
- Bits above count*2 are always 0.
- ACCUM -> EMIT when any of the following holds:
  (a) an accept makes count == 15;
  (b) frag_valid && count + frag_len > 15 with count > 0; the fragment is held and taken after the emit;
  (c) flush && count > 0;
  (d) ending && count > 0.
- flush with count == 0 is a no-op. flush wins over a same-cycle fragment.
- ACCUM -> ENDED when ending && count == 0.
- EMIT:
  - word_valid = 1, word_data = buffer, word_units = count; all three stable until word_ready.
  - frag_ready = 0.
  - On word_ready: buffer <= 0, count <= 0, word_cnt += 1 (saturates at 2^STAT_W-1).
  - Next state: ENDED if ending is set, else ACCUM.
  - word_valid deasserts the cycle after the handshake; there is no back-to-back emit.
- ending flag: set by test_ending in any state, sticky. In ACCUM it stops acceptance the same cycle. In EMIT it is honoured after the handshake completes.
- ENDED: test_has_ended = 1, frag_ready = 0, word_valid = 0, flush ignored. Exits only by reset.
- frag_len == 0 with frag_valid: frag_ready follows the rule above and no state changes.

Decomposition:
- Package nios2_oci_dct_pkg holds BUF_W, UNIT_W, CNT_W, MAX_UNITS, the state enum (ACCUM/EMIT/ENDED) and a function for fits = count + len <= MAX_UNITS.
- One natural sub-module: nios2_oci_dct_insert. It is combinational: buffer, count, frag_data and frag_len in; next buffer out, with shift and mask by unit.
- The FSM, counters and handshake stay in the top.

Test Plan:
1. Reset, then frags len=3 data=0x2D repeated 5x -> dct_count 3,6,9,12,15. After 5th accept, word_valid=1, word_data=0x2D2D2D2D2D packed LSB-first (0x2DB6DB6D), word_units=15. word_ready=1 -> word_cnt=1, dct_count=0.
2. count=14, frag len=2 -> frag_ready=0, EMIT with word_units=14. After handshake the same fragment is accepted: dct_count=2, dct_buffer=frag_data[3:0].
3. count=5, flush and frag_valid same cycle -> fragment not accepted, word_units=5. flush at count=0 -> no word_valid.
4. Hold word_ready=0 for 10 cycles in EMIT -> word_data/word_units stable, frag_ready=0. Then word_ready=1 -> single handshake.
5. count=7, pulse test_ending -> frag_ready drops the same cycle, word_units=7 emitted, then test_has_ended=1 held. Later flush and frag_valid are ignored.
6. Assert reset_n=0 mid-EMIT -> all outputs 0 immediately. After release, dct_count=0, word_cnt=0, test_has_ended=0.
